// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit (sign/zero/upper/branch) behind a two-entry skid buffer.
// Define IMM_EXT_SHIFT_EN to implement upper/branch modes; otherwise they return err.
module imm_extend_pipe #(
  parameter int unsigned IN_BITS  = 16,
  parameter int unsigned OUT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_err
);

  localparam int unsigned PAD = OUT_BITS - IN_BITS;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OUT_BITS-1:0] r_main_data;
  logic                r_main_err;
  logic [OUT_BITS-1:0] r_skid_data;
  logic                r_skid_err;

  logic [OUT_BITS-1:0] w_sext;
  logic [OUT_BITS-1:0] w_zext;
  logic [OUT_BITS-1:0] w_ext;
  logic                w_err;
  logic                w_acc;
  logic                w_con;
  logic                w_ld_main;
  logic                w_ld_skid;
  logic                w_mv_skid;

  assign w_sext = {{PAD{in_data[IN_BITS-1]}}, in_data};
  assign w_zext = {{PAD{1'b0}}, in_data};

  always_comb begin
    w_ext = '0;
    w_err = 1'b0;
    case (in_mode)
      2'b00: w_ext = w_sext;
      2'b01: w_ext = w_zext;
`ifdef IMM_EXT_SHIFT_EN
      2'b10: w_ext = {in_data, {PAD{1'b0}}};
      2'b11: w_ext = {w_sext[OUT_BITS-3:0], 2'b00};
`else
      default: begin
        w_ext = '0;
        w_err = 1'b1;
      end
`endif
    endcase
  end

  // Gated by rst so nothing is accepted while the buffer is being cleared.
  assign in_ready  = (r_state != S_FULL) && !rst;
  assign out_valid = (r_state != S_EMPTY);
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

  assign w_acc = in_valid && in_ready;
  assign w_con = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_main   = 1'b0;
    w_ld_skid   = 1'b0;
    w_mv_skid   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = S_ONE;
          w_ld_main   = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_con) begin
          w_ld_main = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_con) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_con) begin
          w_state_nxt = S_ONE;
          w_mv_skid   = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main) begin
        r_main_data <= w_ext;
        r_main_err  <= w_err;
      end else if (w_mv_skid) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_ld_skid) begin
        r_skid_data <= w_ext;
        r_skid_err  <= w_err;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe (default 16 -> 32 widths).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_BITS(16), .OUT_BITS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {err, data}
  function automatic logic [32:0] model(input logic [15:0] d, input logic [1:0] m);
    logic [31:0] s;
    s = d[15] ? (32'hFFFF0000 | {16'h0, d}) : {16'h0, d};
    case (m)
      2'b00: return {1'b0, s};
      2'b01: return {1'b0, 16'h0, d};
`ifdef IMM_EXT_SHIFT_EN
      2'b10: return {1'b0, d, 16'h0};
      default: return {1'b0, s * 32'd4};
`else
      default: return {1'b1, 32'h0};
`endif
    endcase
  endfunction

  task automatic send(input string tag, input logic [15:0] d, input logic [1:0] m,
                      input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    step();
    in_valid = 1'b0;
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"}, out_data, exp_d);
    chk({tag, ".err"}, out_err, exp_e);
  endtask

  initial begin
    logic [15:0] d;
    logic [1:0]  m;
    logic [32:0] e;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
    step();
    chk("rst.in_ready", in_ready, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_data", out_data, 32'h0);
    chk("rst.out_err", out_err, 1'b0);
    rst = 1'b0;
    step();
    chk("post_rst.in_ready", in_ready, 1'b1);

    send("sign8001", 16'h8001, 2'b00, 32'hFFFF8001, 1'b0);
    send("zero8001", 16'h8001, 2'b01, 32'h00008001, 1'b0);
    send("sign7fff", 16'h7FFF, 2'b00, 32'h00007FFF, 1'b0);
`ifdef IMM_EXT_SHIFT_EN
    send("upper1234", 16'h1234, 2'b10, 32'h12340000, 1'b0);
    send("brFFFF", 16'hFFFF, 2'b11, 32'hFFFFFFFC, 1'b0);
    send("br0004", 16'h0004, 2'b11, 32'h00000010, 1'b0);
`else
    send("upper1234", 16'h1234, 2'b10, 32'h0, 1'b1);
    send("brFFFF", 16'hFFFF, 2'b11, 32'h0, 1'b1);
    send("br0004", 16'h0004, 2'b11, 32'h0, 1'b1);
`endif
    step();
    chk("drain.out_valid", out_valid, 1'b0);

    // Backpressure: third word must wait in upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h0001;
    step();
    chk("bp1.in_ready", in_ready, 1'b1);
    in_data = 16'h0002;
    step();
    chk("bp2.in_ready", in_ready, 1'b0);
    chk("bp2.out_data", out_data, 32'h1);
    in_data = 16'h0003;
    step();
    chk("bp3.in_ready", in_ready, 1'b0);
    chk("bp3.out_data_hold", out_data, 32'h1);
    chk("bp3.out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    chk("bp_out2.valid", out_valid, 1'b1);
    chk("bp_out2.data", out_data, 32'h2);
    chk("bp_out2.in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_out3.valid", out_valid, 1'b1);
    chk("bp_out3.data", out_data, 32'h3);
    step();
    chk("bp_end.out_valid", out_valid, 1'b0);

    // Streaming with out_ready high: one result per cycle
    for (int i = 0; i < 16; i++) begin
      d = 16'($urandom);
      m = 2'($urandom_range(3, 0));
      e = model(d, m);
      in_valid = 1'b1; in_data = d; in_mode = m;
      step();
      chk("stream.in_ready", in_ready, 1'b1);
      chk("stream.valid", out_valid, 1'b1);
      chk("stream.data", out_data, e[31:0]);
      chk("stream.err", out_err, e[32]);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end.out_valid", out_valid, 1'b0);

    // Reset while FULL discards both entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b01; in_data = 16'hAAAA;
    step();
    in_data = 16'h5555;
    step();
    in_valid = 1'b0;
    chk("full.in_ready", in_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.out_data", out_data, 32'h0);
    chk("midrst.in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("release.in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    send("fresh", 16'hFFFE, 2'b00, 32'hFFFFFFFE, 1'b0);
    step();
    chk("fresh_end.out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Pipelined, parametrised immediate-extension unit for the MIPS-based soft processor's decode stage. Takes an `IN_BITS` immediate plus a mode code and produces an `OUT_BITS` operand: sign-extended, zero-extended, upper-loaded (LUI) or branch-offset (sign-extended, ×4). Results are registered behind a two-entry valid/ready skid buffer, so decode-to-execute backpressure never drops or reorders immediates.

## Interface
Parameters:
- `IN_BITS`, 16, immediate width; ≥ 2.
- `OUT_BITS`, 32, operand width; must be ≥ `IN_BITS` + 2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream has an immediate.
- `in_ready`  out  1  unit can accept this cycle.
- `in_data`  in  `IN_BITS`  raw immediate.
- `in_mode`  in  2  00 sign, 01 zero, 10 upper, 11 branch.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_data`  out  `OUT_BITS`  extended operand.
- `out_err`  out  1  result came from an unsupported mode.

## Operation
- Accept when `in_valid && in_ready`; consume when `out_valid && out_ready`.
- Extension, all unsigned bit arithmetic, widths exact:
  - sign: upper `OUT_BITS-IN_BITS` bits = `in_data[IN_BITS-1]`, low bits = `in_data`.
  - zero: upper bits 0, low bits = `in_data`.
  - upper: `in_data` placed in top `IN_BITS` bits (shift by `OUT_BITS-IN_BITS`), low bits 0.
  - branch: sign-extended value shifted left 2; top 2 bits of the extended value discarded, bits [1:0] = 0.
- Storage: main register (drives outputs) + skid register; both carry data and err.
- States: EMPTY (nothing held), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept → ONE.
  - ONE: accept only → FULL; consume only → EMPTY; accept+consume → ONE, main loads new result.
  - FULL: no accept possible; consume → ONE, skid moves to main.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL; registered/state-derived, never combinationally dependent on `out_ready`.
- `out_valid` = 1 in ONE and FULL.
- Strict FIFO order; no result dropped or duplicated.
- `out_data`/`out_err` hold stable while `out_valid && !out_ready`.

## Timing
- Latency: 1 cycle, accept at edge N → `out_valid` high after edge N.
- Throughput: 1 result/cycle with `out_ready` held high.
- Reset: state EMPTY; `in_ready`=0 during reset cycle, 1 first cycle after; `out_valid`=0, `out_data`=0, `out_err`=0; both registers cleared.
- Reset mid-operation: all held results discarded, no output valid the following cycle.
- Simultaneous accept+consume in ONE: new result visible next cycle, old one consumed this cycle.
- `in_valid` while `in_ready`=0: ignored, upstream holds.

## Configuration
- `IMM_EXT_SHIFT_EN` defined: upper and branch modes implemented as above; `out_err` always 0.
- Not defined: modes 10/11 unsupported; result `out_data`=0, `out_err`=1, still queued and ordered normally; modes 00/01 unaffected; shift logic absent from netlist.

## Test plan
- Reset, then sign mode `in_data`=0x8001 → next cycle `out_valid`=1, `out_data`=0xFFFF8001, `out_err`=0.
- Zero mode 0x8001 → 0x00008001; sign mode 0x7FFF → 0x00007FFF.
- With `IMM_EXT_SHIFT_EN`: upper 0x1234 → 0x12340000; branch 0xFFFF → 0xFFFFFFFC; branch 0x0004 → 0x00000010. Without macro: both give `out_data`=0, `out_err`=1.
- Backpressure: `out_ready`=0, present 0x0001,0x0002,0x0003 back-to-back → first two accepted, `in_ready`=0 from third cycle, 0x0003 held; raise `out_ready` → outputs 0x1,0x2,0x3 in order, one per cycle, none lost.
- Streaming: 16 random immediates/modes with `out_ready`=1 → 16 results on consecutive cycles matching model, 1-cycle latency.
- Assert `rst` while FULL → next cycle `out_valid`=0, `out_data`=0; after release `in_ready`=1, fresh input yields correct result.
